// File: rtl/x_sub_u.sv
// Batch-norm statistics stage: pipelined FP16 mean and variance of one N-sample vector.
// Every cycle's vector flows independently; the mean is out L+1 edges after capture, the variance 2L+4 edges after.
module x_sub_u #(
    parameter int          DATA_WIDTH       = 16,
    parameter int          size             = 4,
    parameter logic [15:0] quarter          = 16'h3400,
    parameter int          channel          = 1,
    parameter int          size_div_channel = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DATA_WIDTH*size_div_channel-1:0] x,
    output logic [DATA_WIDTH-1:0]                u_Out,
    output logic [DATA_WIDTH-1:0]                AvgOut_temp
);

    localparam int N = size_div_channel;
    localparam int L = $clog2(N);

    if (DATA_WIDTH != 16 || channel != 1 || size != channel * size_div_channel || N < 2 || (1 << L) != N) begin : g_bad_cfg
        $error("x_sub_u: unsupported parameter set");
    end

    localparam logic [15:0] FP_NAN = 16'h7E00;

    // Round a normalised significand (hidden bit at n[13], guard n[2], round/sticky n[1:0]) to nearest-even and pack.
    function automatic logic [15:0] fp_round_pack(input logic s, input logic signed [7:0] e, input logic [13:0] n);
        logic              inc;
        logic              c;
        logic [9:0]        f;
        logic signed [7:0] er;
        logic [15:0]       res;
        inc    = n[2] & (n[3] | n[1] | n[0]);
        {c, f} = {1'b0, n[12:3]} + {10'd0, inc};
        er     = c ? (e + 8'sd1) : e;
        if (!n[13]) begin
            res = 16'h0000;
        end else if (er >= 8'sd31) begin
            res = {s, 5'h1F, 10'h000};
        end else if (er <= 8'sd0) begin
            res = 16'h0000;
        end else begin
            res = {s, er[4:0], f};
        end
        return res;
    endfunction

    function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [15:0]       big, sml, res;
        logic [4:0]        d;
        logic [13:0]       m_big, m_sml, m_sh, mask, n;
        logic [14:0]       sum;
        logic [3:0]        lz;
        logic signed [7:0] e;
        a_nan  = (&a[14:10]) & (|a[9:0]);
        b_nan  = (&b[14:10]) & (|b[9:0]);
        a_inf  = (&a[14:10]) & ~(|a[9:0]);
        b_inf  = (&b[14:10]) & ~(|b[9:0]);
        a_zero = ~(|a[14:10]);
        b_zero = ~(|b[14:10]);
        if (a[14:0] >= b[14:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d     = big[14:10] - sml[14:10];
        m_big = {1'b1, big[9:0], 3'b000};
        m_sml = {1'b1, sml[9:0], 3'b000};
        // Shifts of 14 or more leave mask all-ones, so the whole small operand collapses into sticky.
        mask  = (14'd1 << d) - 14'd1;
        m_sh  = (m_sml >> d) | {13'd0, |(m_sml & mask)};
        if (big[15] == sml[15]) begin
            sum = {1'b0, m_big} + {1'b0, m_sh};
        end else begin
            sum = {1'b0, m_big} - {1'b0, m_sh};
        end
        lz = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (sum[i]) begin
                lz = 4'(13 - i);
            end
        end
        if (sum[14]) begin
            n = sum[14:1] | {13'd0, sum[0]};
            e = $signed({3'b000, big[14:10]}) + 8'sd1;
        end else begin
            n = sum[13:0] << lz;
            e = $signed({3'b000, big[14:10]}) - $signed({4'b0000, lz});
        end
        if (a_nan || b_nan) begin
            res = FP_NAN;
        end else if (a_inf && b_inf && (a[15] != b[15])) begin
            res = FP_NAN;
        end else if (a_inf) begin
            res = {a[15], 5'h1F, 10'h000};
        end else if (b_inf) begin
            res = {b[15], 5'h1F, 10'h000};
        end else if (a_zero && b_zero) begin
            res = 16'h0000;
        end else if (a_zero) begin
            res = b;
        end else if (b_zero) begin
            res = a;
        end else begin
            res = fp_round_pack(big[15], e, n);
        end
        return res;
    endfunction

    function automatic logic [15:0] fp_sub(input logic [15:0] a, input logic [15:0] b);
        return fp_add(a, b ^ 16'h8000);
    endfunction

    function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
        logic [21:0]       p;
        logic [13:0]       n;
        logic signed [7:0] e;
        logic [15:0]       res;
        a_nan  = (&a[14:10]) & (|a[9:0]);
        b_nan  = (&b[14:10]) & (|b[9:0]);
        a_inf  = (&a[14:10]) & ~(|a[9:0]);
        b_inf  = (&b[14:10]) & ~(|b[9:0]);
        a_zero = ~(|a[14:10]);
        b_zero = ~(|b[14:10]);
        s      = a[15] ^ b[15];
        p      = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        e      = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
        if (p[21]) begin
            n = {p[21:9], |p[8:0]};
            e = e + 8'sd1;
        end else begin
            n = {p[20:8], |p[7:0]};
        end
        if (a_nan || b_nan) begin
            res = FP_NAN;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            res = FP_NAN;
        end else if (a_inf || b_inf) begin
            res = {s, 5'h1F, 10'h000};
        end else if (a_zero || b_zero) begin
            res = 16'h0000;
        end else begin
            res = fp_round_pack(s, e, n);
        end
        return res;
    endfunction

    // Adder trees use heap numbering: leaves at N..2N-1, node k sums nodes 2k and 2k+1, root at 1.
    logic [DATA_WIDTH-1:0] r_t1 [1:2*N-1];
    logic [DATA_WIDTH-1:0] r_t2 [1:2*N-1];
    logic [DATA_WIDTH-1:0] r_xd [0:L][0:N-1];
    logic [DATA_WIDTH-1:0] r_u1 [0:N-1];

    // Whole pipeline: capture, mean tree, sample delay line, deviation, square, variance tree, outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k < 2 * N; k++) begin
                r_t1[k] <= 16'h0000;
                r_t2[k] <= 16'h0000;
            end
            for (int i = 0; i < N; i++) begin
                r_u1[i] <= 16'h0000;
                for (int j = 0; j <= L; j++) begin
                    r_xd[j][i] <= 16'h0000;
                end
            end
            u_Out       <= 16'h0000;
            AvgOut_temp <= 16'h0000;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_t1[N+i]  <= x[DATA_WIDTH*(N-i)-1 -: DATA_WIDTH];
                r_xd[0][i] <= r_t1[N+i];
                for (int j = 1; j <= L; j++) begin
                    r_xd[j][i] <= r_xd[j-1][i];
                end
                r_u1[i]    <= fp_sub(r_xd[L][i], u_Out);
                r_t2[N+i]  <= fp_mul(r_u1[i], r_u1[i]);
            end
            for (int k = 1; k < N; k++) begin
                r_t1[k] <= fp_add(r_t1[2*k], r_t1[2*k+1]);
                r_t2[k] <= fp_add(r_t2[2*k], r_t2[2*k+1]);
            end
            u_Out       <= fp_mul(r_t1[1], quarter);
            AvgOut_temp <= fp_mul(r_t2[1], quarter);
        end
    end

endmodule

// File: tb/tb_x_sub_u.sv
// Bench for x_sub_u: real-arithmetic FP16 reference model, directed cases with literal expectations, then random traffic.
module tb_x_sub_u;

    logic        clk;
    logic        reset;
    logic [63:0] x;
    logic [15:0] u_Out;
    logic [15:0] AvgOut_temp;

    int checks = 0;
    int errors = 0;
    logic [63:0] cap[$];

    x_sub_u #(
        .DATA_WIDTH(16), .size(4), .quarter(16'h3400), .channel(1), .size_div_channel(4)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .u_Out(u_Out), .AvgOut_temp(AvgOut_temp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real p2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) begin
            for (int i = 0; i < k; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -k; i++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real v;
        if (h[14:10] == 5'd0) return 0.0;
        v = real'(1024 + int'(h[9:0])) * p2(int'(h[14:10]) - 25);
        return h[15] ? -v : v;
    endfunction

    // Exact real value rounded to an 11-bit significand (nearest-even), then flush/saturate.
    function automatic logic [15:0] r2h(input real r);
        logic s;
        real  m, p, fr, rem;
        int   e, fi;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        p = 1.0;
        while (m >= 2.0 * p) begin p = p * 2.0; e++; end
        while (m < p) begin p = p / 2.0; e--; end
        fr  = m / p * 1024.0;
        fi  = $rtoi(fr);
        rem = fr - real'(fi);
        if (rem > 0.5 || (rem == 0.5 && (fi % 2) == 1)) fi++;
        if (fi == 2048) begin fi = 1024; e++; end
        if (e > 15) return {s, 5'h1F, 10'h000};
        if (e < -14) return 16'h0000;
        return {s, 5'(e + 15), 10'(fi - 1024)};
    endfunction

    function automatic bit is_nan(input logic [15:0] h);
        return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
    endfunction

    function automatic bit is_inf(input logic [15:0] h);
        return (h[14:10] == 5'h1F) && (h[9:0] == 10'd0);
    endfunction

    function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
        if (is_nan(a) || is_nan(b)) return 16'h7E00;
        if (is_inf(a) && is_inf(b) && a[15] != b[15]) return 16'h7E00;
        if (is_inf(a)) return {a[15], 15'h7C00};
        if (is_inf(b)) return {b[15], 15'h7C00};
        return r2h(h2r(a) + h2r(b));
    endfunction

    function automatic logic [15:0] m_sub(input logic [15:0] a, input logic [15:0] b);
        return m_add(a, b ^ 16'h8000);
    endfunction

    function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
        bit za, zb;
        za = (a[14:10] == 5'd0);
        zb = (b[14:10] == 5'd0);
        if (is_nan(a) || is_nan(b)) return 16'h7E00;
        if ((is_inf(a) && zb) || (is_inf(b) && za)) return 16'h7E00;
        if (is_inf(a) || is_inf(b)) return {a[15] ^ b[15], 15'h7C00};
        return r2h(h2r(a) * h2r(b));
    endfunction

    function automatic logic [15:0] el(input logic [63:0] v, input int i);
        return v[63-16*i -: 16];
    endfunction

    function automatic logic [15:0] m_mean(input logic [63:0] v);
        return m_mul(m_add(m_add(el(v, 0), el(v, 1)), m_add(el(v, 2), el(v, 3))), 16'h3400);
    endfunction

    function automatic logic [15:0] m_var(input logic [63:0] v);
        logic [15:0] mu;
        logic [15:0] q [4];
        mu = m_mean(v);
        for (int i = 0; i < 4; i++) begin
            q[i] = m_mul(m_sub(el(v, i), mu), m_sub(el(v, i), mu));
        end
        return m_mul(m_add(m_add(q[0], q[1]), m_add(q[2], q[3])), 16'h3400);
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive just after a falling edge, record the capture, compare against the model at the next falling edge.
    task automatic step(input logic [63:0] xv, input logic rv);
        int n;
        x     = xv;
        reset = rv;
        @(posedge clk);
        if (!reset) cap.delete();
        else cap.push_back(x);
        if (cap.size() > 9) void'(cap.pop_front());
        @(negedge clk);
        n = cap.size();
        if (!reset) begin
            chk("u_in_reset", u_Out, 16'h0000);
            chk("v_in_reset", AvgOut_temp, 16'h0000);
        end else begin
            chk("u_model", u_Out, (n >= 4) ? m_mean(cap[n-4]) : 16'h0000);
            chk("v_model", AvgOut_temp, (n >= 9) ? m_var(cap[n-9]) : 16'h0000);
        end
        #1;
    endtask

    function automatic logic [15:0] rand_half();
        logic s;
        logic [9:0] m;
        int cat;
        s   = 1'($urandom_range(0, 1));
        m   = 10'($urandom_range(0, 1023));
        cat = $urandom_range(0, 19);
        case (cat)
            0:       return {s, 15'h0000};
            1:       return {s, 5'd0, m | 10'd1};
            2:       return {s, 15'h7C00};
            3:       return {s, 5'h1F, m | 10'd1};
            4:       return {s, 5'($urandom_range(24, 30)), m};
            default: return {s, 5'($urandom_range(12, 18)), m};
        endcase
    endfunction

    localparam logic [63:0] V_A   = 64'h4000_4200_4400_4500;
    localparam logic [63:0] V_NEG = 64'hBC00_C000_C200_C400;
    localparam logic [63:0] V_ONE = 64'h3C00_3C00_3C00_3C00;
    localparam logic [63:0] V_NAN = 64'h7E00_3C00_4000_4200;
    localparam logic [63:0] V_ZER = 64'h0000_8000_4000_C000;

    initial begin
        logic [63:0] v;
        logic        r;
        x     = 64'd0;
        reset = 1'b0;

        chk("pin_mean_a", m_mean(V_A), 16'h4300);
        chk("pin_var_a", m_var(V_A), 16'h3D00);
        chk("pin_mean_neg", m_mean(V_NEG), 16'hC100);
        chk("pin_var_zer", m_var(V_ZER), 16'h4000);
        chk("pin_tie_even", m_add(16'h3C00, 16'h1000), 16'h3C00);
        chk("pin_tie_odd", m_add(16'h3C01, 16'h1000), 16'h3C02);
        chk("pin_ovf", m_mul(16'h7BFF, 16'h4000), 16'h7C00);
        chk("pin_flush", m_sub(16'h0401, 16'h0400), 16'h0000);
        chk("pin_inf_zero", m_mul(16'h7C00, 16'h0000), 16'h7E00);

        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) step(V_A, 1'b0);
        chk("rst_u", u_Out, 16'h0000);
        chk("rst_v", AvgOut_temp, 16'h0000);

        for (int k = 0; k < 10; k++) begin
            step(V_A, 1'b1);
            if (k == 2) chk("a_u_E2", u_Out, 16'h0000);
            if (k == 3) chk("a_u_E3", u_Out, 16'h4300);
            if (k == 7) chk("a_v_E7", AvgOut_temp, 16'h0000);
            if (k == 8) chk("a_v_E8", AvgOut_temp, 16'h3D00);
        end

        step(V_A, 1'b0);
        step(V_A, 1'b0);
        chk("mid_rst_u", u_Out, 16'h0000);
        chk("mid_rst_v", AvgOut_temp, 16'h0000);
        for (int k = 0; k < 10; k++) begin
            step(V_NEG, 1'b1);
            if (k == 2) chk("neg_u_E2", u_Out, 16'h0000);
            if (k == 3) chk("neg_u_E3", u_Out, 16'hC100);
            if (k == 8) chk("neg_v_E8", AvgOut_temp, 16'h3D00);
        end

        for (int k = 0; k < 10; k++) step(V_ONE, 1'b1);
        chk("one_u", u_Out, 16'h3C00);
        chk("one_v", AvgOut_temp, 16'h0000);

        step(V_A, 1'b1);
        for (int k = 1; k < 10; k++) begin
            step(V_ONE, 1'b1);
            if (k == 3) chk("b2b_u_A", u_Out, 16'h4300);
            if (k == 4) chk("b2b_u_B", u_Out, 16'h3C00);
            if (k == 8) chk("b2b_v_A", AvgOut_temp, 16'h3D00);
            if (k == 9) chk("b2b_v_B", AvgOut_temp, 16'h0000);
        end

        for (int k = 0; k < 10; k++) step(V_NAN, 1'b1);
        chk("nan_u", u_Out, 16'h7E00);
        chk("nan_v", AvgOut_temp, 16'h7E00);

        for (int k = 0; k < 10; k++) step(V_ZER, 1'b1);
        chk("zer_u", u_Out, 16'h0000);
        chk("zer_v", AvgOut_temp, 16'h4000);

        v = V_A;
        for (int c = 0; c < 1500; c++) begin
            r = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 4) != 0) begin
                v = {rand_half(), rand_half(), rand_half(), rand_half()};
            end
            step(v, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/x_sub_u.md
# x_sub_u

Batch-normalisation statistics stage for the FP16 BN datapath. It takes one vector of `size_div_channel` IEEE-754 half-precision samples and produces the mean u and the variance mean((x−u)²). It is a fully pipelined, free-running block: it accepts a new vector every cycle, and each result appears a fixed number of cycles later. It feeds the normalisation stage, which consumes u and σ².

## Interface
- `DATA_WIDTH`, 16, width of one FP16 sample; only 16 is supported.
- `size`, 4, total samples per vector; must equal `channel*size_div_channel`.
- `quarter`, 16'h3400, FP16 constant equal to 1/`size_div_channel` (0.25), used as the averaging multiplier.
- `channel`, 1, number of channels; only 1 is supported.
- `size_div_channel`, 4, samples per channel, N; must be a power of two ≥ 2. L = log2(N).

- `clk` input 1: clock; all registers update on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `x` input `DATA_WIDTH*size_div_channel`: sample vector; element i = `x[DATA_WIDTH*(N-i)-1 -: DATA_WIDTH]`, so element 0 is the MSB slice.
- `u_Out` output `DATA_WIDTH`: registered FP16 mean.
- `AvgOut_temp` output `DATA_WIDTH`: registered FP16 variance.

## Operation
- Stage S0: register `x` into the internal vector `xr`.
- Stages S1..SL: binary adder tree over the N elements, in pairs (0+1, 2+3, ...).
- Stage S(L+1): `AvgOut` = sum × `quarter`. This is the mean, driven on `u_Out`.
- In parallel, `xr` is delayed through L+1 registers so it aligns with `AvgOut`.
- Stage S(L+2): `u1[i]` = x_i − mean, for each element (FP16 subtract).
- Stage S(L+3): `u1_2[i]` = `u1[i]` × `u1[i]`. `u1_2` is an N×16 bus.
- Stages S(L+4)..S(2L+3): adder tree over `u1_2`, same pairing as above.
- Stage S(2L+4): variance = sum × `quarter`, driven on `AvgOut_temp`.

FP16 arithmetic rules:
- Adder, subtractor and multiplier use round-to-nearest-even.
- Subnormal inputs and results flush to +0.
- Overflow saturates to ±Inf.
- Any NaN input produces canonical NaN 16'h7E00.
- Exact cancellation produces +0.
- Adder and multiplier are combinational between stage registers (one operation per stage).

Reset:
- While `reset` = 0, every pipeline register, `u_Out` and `AvgOut_temp` are cleared to 16'h0000 asynchronously.
- Reset asserted mid-computation discards all in-flight vectors.
- After release, the outputs stay 0 until the first post-reset vector reaches them.

There is no handshake. Every cycle's `x` is a new vector, and consecutive vectors never interfere.

## Timing
- Let edge E0 be the first rising edge at which `x` (stable, `reset` = 1) is captured.
- `u_Out` reflects that vector after edge E(L+1), which is E3 for N = 4.
- `AvgOut_temp` reflects it after edge E(2L+4), which is E8 for N = 4.
- Throughput is one vector per clock. The outputs hold their value while `x` is held constant.
- Reset has priority over the clock.

## Test plan
- Apply `x`=64'h4000_4200_4400_4500 (2, 3, 4, 5) after reset release. Required: `u_Out`=16'h4300 (3.5) after E3; `AvgOut_temp`=16'h3D00 (1.25) after E8. Internally `u1` = {BE00, B800, 3800, 3E00} and `u1_2` = {4080, 3400, 3400, 4080}.
- Assert reset mid-run, then apply `x`=64'hBC00_C000_C200_C400 (−1, −2, −3, −4). Required: both outputs are 0 during reset; then `u_Out`=16'hC100 (−2.5) after E3 and `AvgOut_temp`=16'h3D00 after E8.
- Apply identical samples, `x`=64'h3C00_3C00_3C00_3C00. Required: `u_Out`=16'h3C00 and `AvgOut_temp`=16'h0000.
- Apply back-to-back vectors on consecutive cycles (vector A, then B). Required: A's results and B's results appear on consecutive cycles at the same latencies, with no mixing.
- Apply a vector with one NaN (7E00) element. Required: `u_Out` = `AvgOut_temp` = 16'h7E00.
- Apply mixed zeros, `x`=64'h0000_8000_4000_C000 (0, −0, 2, −2). Required: `u_Out`=16'h0000 and `AvgOut_temp`=16'h4000 (2.0).
